// File: rtl/calc_sequencer.sv
// calc_sequencer: four-function calculator sequencer with shift-add multiply and restoring divide.
module calc_sequencer #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enter,
  input  logic           clr,
  input  logic [1:0]     op_sel,
  input  logic [N-1:0]   operand_a,
  input  logic [N-1:0]   operand_b,
  output logic           load_a,
  output logic           load_b,
  output logic [2*N-1:0] result,
  output logic           result_valid,
  output logic           negative,
  output logic           error,
  output logic           busy,
  output logic [1:0]     state
);
  typedef enum logic [1:0] {GET_A = 2'b00, GET_B = 2'b01, COMPUTE = 2'b10, DONE = 2'b11} state_t;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  state_t         state_q;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q, mcand_q, result_q, acc_d, sum_w, dif_w;
  logic [N-1:0]   mplier_q, rem_q, quo_q, dvs_q, quo_d;
  logic [N:0]     shl_w, rem_d;
  logic           neg_q, err_q, ge_w, fast_w;
  assign sum_w  = (2*N)'(operand_a) + (2*N)'(operand_b);
  assign dif_w  = (2*N)'(operand_a) - (2*N)'(operand_b);
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign shl_w  = {rem_q, quo_q[N-1]};
  assign ge_w   = shl_w >= {1'b0, dvs_q};
  assign rem_d  = ge_w ? shl_w - {1'b0, dvs_q} : shl_w;
  assign quo_d  = {quo_q[N-2:0], ge_w};
  assign fast_w = !op_q[1] || (op_q[0] && operand_b == '0);
  assign load_a = !reset && !clr && enter && (state_q == GET_A || state_q == DONE);
  assign load_b = !reset && !clr && enter && state_q == GET_B;
  assign result       = result_q;
  assign negative     = neg_q;
  assign error        = err_q;
  assign busy         = state_q == COMPUTE;
  assign result_valid = state_q == DONE;
  assign state        = state_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= GET_A;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (clr) begin
      state_q  <= GET_A;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        GET_A: if (enter) state_q <= GET_B;
        GET_B: if (enter) begin
          op_q    <= op_sel;
          cnt_q   <= '0;
          state_q <= COMPUTE;
        end
        COMPUTE: if (cnt_q == '0) begin
          cnt_q    <= CW'(1);
          acc_q    <= '0;
          mcand_q  <= (2*N)'(operand_a);
          mplier_q <= operand_b;
          rem_q    <= '0;
          quo_q    <= operand_a;
          dvs_q    <= operand_b;
          // Add, subtract and divide-by-zero finish on the operand-read cycle.
          if (fast_w) begin
            result_q <= op_q[1] ? '1 : op_q[0] ? dif_w : sum_w;
            neg_q    <= op_q == 2'b01 && operand_a < operand_b;
            err_q    <= op_q[1];
            state_q  <= DONE;
          end
        end else begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          rem_q    <= rem_d[N-1:0];
          quo_q    <= quo_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q <= op_q[0] ? {rem_d[N-1:0], quo_d} : acc_d;
            state_q  <= DONE;
          end
        end
        DONE: if (enter) begin
          neg_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= GET_B;
        end
        default: state_q <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer at N=4.
module tb_calc_sequencer;
  logic       clk = 1'b0, reset = 1'b1, enter = 1'b0, clr = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic [3:0] operand_a = '0, operand_b = '0;
  logic       load_a, load_b, result_valid, negative, error, busy;
  logic [7:0] result;
  logic [1:0] state;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [7:0] res; logic neg; logic err; int lat;} exp_t;
  exp_t sb[$];
  calc_sequencer #(.N(4)) dut (
    .clk(clk), .reset(reset), .enter(enter), .clr(clr), .op_sel(op_sel),
    .operand_a(operand_a), .operand_b(operand_b), .load_a(load_a), .load_b(load_b),
    .result(result), .result_valid(result_valid), .negative(negative), .error(error),
    .busy(busy), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    exp_t e;
    int ia, ib;
    ia = a;
    ib = b;
    e.neg = 1'b0;
    e.err = 1'b0;
    e.lat = 6;
    e.res = '0;
    case (op)
      2'b00: begin e.res = 8'(ia + ib); e.lat = 2; end
      2'b01: begin e.res = 8'(ia - ib); e.neg = ia < ib; e.lat = 2; end
      2'b10: e.res = 8'(ia * ib);
      default: if (ib == 0) begin
        e.res = 8'hFF; e.err = 1'b1; e.lat = 2;
      end else e.res = 8'((ia % ib) * 16 + ia / ib);
    endcase
    return e;
  endfunction
  task automatic do_calc(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    exp_t e;
    int k, nb;
    @(negedge clk);
    operand_a = a;
    enter = 1'b1;
    #1;
    vectors++;
    if (load_a !== 1'b1) begin miscompares++; $display("FAIL load_a_pulse: got %b want 1", load_a); end
    @(negedge clk);
    enter = 1'b0;
    vectors++;
    if ({state, result_valid, negative, error} !== 5'b01000) begin
      miscompares++; $display("FAIL get_b_entry: state/rv/neg/err got %b want 01000", {state, result_valid, negative, error});
    end
    @(negedge clk);
    operand_b = b;
    op_sel = op;
    enter = 1'b1;
    #1;
    vectors++;
    if ({load_a, load_b} !== 2'b01) begin miscompares++; $display("FAIL load_b_pulse: load_a/load_b got %b want 01", {load_a, load_b}); end
    sb.push_back(model(a, b, op));
    k = 0;
    nb = 0;
    do begin
      @(negedge clk);
      enter = 1'b0;
      op_sel = ~op;
      k++;
      if (busy) nb++;
    end while (!result_valid && k < 40);
    e = sb.pop_front();
    vectors++;
    if (result_valid !== 1'b1) begin miscompares++; $display("FAIL done_timeout: a=%0d b=%0d op=%0d no result_valid", a, b, op); end
    vectors++;
    if (result !== e.res) begin miscompares++; $display("FAIL result: a=%0d b=%0d op=%0d got %h want %h", a, b, op, result, e.res); end
    vectors++;
    if ({negative, error} !== {e.neg, e.err}) begin
      miscompares++; $display("FAIL flags: a=%0d b=%0d op=%0d neg/err got %b%b want %b%b", a, b, op, negative, error, e.neg, e.err);
    end
    vectors++;
    if (k !== e.lat) begin miscompares++; $display("FAIL latency: a=%0d b=%0d op=%0d got %0d want %0d", a, b, op, k, e.lat); end
    vectors++;
    if (nb !== e.lat - 1) begin miscompares++; $display("FAIL busy_cycles: a=%0d b=%0d op=%0d got %0d want %0d", a, b, op, nb, e.lat - 1); end
  endtask
  task automatic test_reset();
    enter = 1'b1;
    #1;
    vectors++;
    if ({load_a, load_b, state, result, result_valid, negative, error, busy} !== 16'h0) begin
      miscompares++; $display("FAIL reset_state: got %h want 0", {load_a, load_b, state, result, result_valid, negative, error, busy});
    end
    @(negedge clk);
    enter = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (state !== 2'b00) begin miscompares++; $display("FAIL reset_release: state got %b want 00", state); end
  endtask
  task automatic test_spec_vectors();
    do_calc(4'd9, 4'd7, 2'b00);
    do_calc(4'd3, 4'd5, 2'b01);
    do_calc(4'd15, 4'd15, 2'b10);
    do_calc(4'd13, 4'd4, 2'b11);
    do_calc(4'd13, 4'd0, 2'b11);
    do_calc(4'd9, 4'd0, 2'b10);
    do_calc(4'd0, 4'd7, 2'b11);
  endtask
  task automatic test_hold();
    do_calc(4'd13, 4'd4, 2'b11);
    repeat (3) begin
      @(negedge clk);
      op_sel = 2'($urandom_range(0, 3));
      operand_a = 4'($urandom_range(0, 15));
      operand_b = 4'($urandom_range(0, 15));
      vectors++;
      if ({result_valid, result} !== 9'h113) begin miscompares++; $display("FAIL done_hold: rv/result got %h want 113", {result_valid, result}); end
    end
  endtask
  task automatic test_back_to_back();
    repeat (10) do_calc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask
  task automatic test_abort();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    operand_a = 4'd15;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    operand_b = 4'd15;
    op_sel = 2'b10;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b1;
    #1;
    vectors++;
    if ({load_a, load_b, busy} !== 3'b001) begin miscompares++; $display("FAIL enter_in_compute: load_a/load_b/busy got %b want 001", {load_a, load_b, busy}); end
    @(negedge clk);
    enter = 1'b0;
    vectors++;
    if (state !== 2'b10) begin miscompares++; $display("FAIL compute_stays: state got %b want 10", state); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({state, result, result_valid, negative, error, busy, load_a, load_b} !== 16'h0) begin
      miscompares++; $display("FAIL async_abort: got %h want 0", {state, result, result_valid, negative, error, busy, load_a, load_b});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      vectors++;
      if ({state, result_valid} !== 3'b000) begin miscompares++; $display("FAIL idle_after_reset: state/rv got %b want 000", {state, result_valid}); end
    end
    enter = 1'b1;
    #1;
    vectors++;
    if (load_a !== 1'b1) begin miscompares++; $display("FAIL load_a_after_reset: got %b want 1", load_a); end
    @(negedge clk);
    enter = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++;
    if (state !== 2'b00) begin miscompares++; $display("FAIL clr_in_get_b: state got %b want 00", state); end
  endtask
  task automatic test_clr();
    do_calc(4'd3, 4'd5, 2'b01);
    @(negedge clk);
    enter = 1'b1;
    clr = 1'b1;
    #1;
    vectors++;
    if ({load_a, load_b} !== 2'b00) begin miscompares++; $display("FAIL clr_priority: load_a/load_b got %b want 00", {load_a, load_b}); end
    @(negedge clk);
    enter = 1'b0;
    clr = 1'b0;
    vectors++;
    if ({state, result, result_valid, negative, error} !== 13'h0) begin
      miscompares++; $display("FAIL clr_done: got %h want 0", {state, result, result_valid, negative, error});
    end
    do_calc(4'd7, 4'd6, 2'b10);
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    op_sel = 2'b10;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++;
    if ({state, result, busy} !== 11'h0) begin miscompares++; $display("FAIL clr_compute: state/result/busy got %h want 0", {state, result, busy}); end
    repeat (8) @(negedge clk);
    vectors++;
    if ({state, result_valid, result} !== 11'h0) begin miscompares++; $display("FAIL clr_no_result: got %h want 0", {state, result_valid, result}); end
  endtask
  initial begin
    test_reset();
    test_spec_vectors();
    test_hold();
    test_back_to_back();
    test_abort();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enter  input  1  debounced single-cycle pulse from the enter button.
REQ-005 SHALL have port clr  input  1  synchronous clear request.
REQ-006 SHALL have port op_sel  input  2  operator select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 SHALL have port operand_a  input  N  registered operand A, returned from its operand load register.
REQ-008 SHALL have port operand_b  input  N  registered operand B, returned from its operand load register.
REQ-009 SHALL have port load_a  output  1  load enable for the operand A register.
REQ-010 SHALL have port load_b  output  1  load enable for the operand B register.
REQ-011 SHALL have port result  output  2N  registered calculation result.
REQ-012 SHALL have port result_valid  output  1  high while result is final.
REQ-013 SHALL have port negative  output  1  subtraction result below zero.
REQ-014 SHALL have port error  output  1  divide by zero.
REQ-015 SHALL have port busy  output  1  high while in COMPUTE.
REQ-016 SHALL have port state  output  2  current state for LEDs: 00 GET_A, 01 GET_B, 10 COMPUTE, 11 DONE.

Function
REQ-017 SHALL implement FSM states GET_A, GET_B, COMPUTE, DONE.
REQ-018 load_a SHALL equal (state==GET_A && enter) combinationally; on the same edge, GET_A->GET_B.
REQ-019 load_b SHALL equal (state==GET_B && enter) combinationally; on the same edge, latch op_sel into an internal op register and go GET_B->COMPUTE.
REQ-020 COMPUTE SHALL first read operand_a/operand_b on its first cycle, which is one cycle after load_b.
REQ-021 Add SHALL set result = zero-extended a+b and complete in 1 COMPUTE cycle, so DONE starts 2 cycles after the load_b cycle.
REQ-022 Subtract SHALL set result = (a-b) as 2N-bit two's complement and negative = (a<b); latency is the same as add.
REQ-023 Multiply SHALL produce the unsigned product by iterative shift-add: 1 init cycle plus N iteration cycles in COMPUTE, so DONE starts N+2 cycles after the load_b cycle.
REQ-024 Divide SHALL use restoring division with latency equal to multiply and produce result = {remainder[N-1:0], quotient[N-1:0]}.
REQ-025 Divide with operand_b==0 SHALL set error=1 and result = all ones, and enter DONE after 1 COMPUTE cycle.
REQ-026 In DONE, result_valid SHALL be 1 and result, negative and error SHALL hold stable.
REQ-027 enter in DONE SHALL act as GET_A entry: load_a=1, clear result_valid/negative/error, go to GET_B (chained new calculation).
REQ-028 enter during COMPUTE SHALL be ignored, with no loads and no state change.
REQ-029 op_sel changes SHALL be ignored except on the load_b cycle.
REQ-030 clr SHALL force state to GET_A on the next edge, zero result and all flags, and abort any iteration; clr SHALL take priority over enter in the same cycle, with load_a and load_b forced to 0.
REQ-031 busy SHALL equal (state==COMPUTE); result_valid SHALL equal (state==DONE).
REQ-032 result SHALL update only at COMPUTE completion, on clr or on reset; intermediate iteration values SHALL NOT be visible on result.

Reset
REQ-033 reset high SHALL immediately, without waiting for clk, force state GET_A, result 0, result_valid/negative/error/busy 0, and clear internal op and iteration registers.
REQ-034 Reset asserted mid-COMPUTE SHALL abandon the operation; after release the block SHALL wait in GET_A with no spurious result_valid.
REQ-035 load_a/load_b SHALL be 0 whenever reset is high.

Verification
REQ-036 N=4, a=9 loaded, b=7 loaded, op=00 -> result=0x10 and result_valid 2 cycles after the load_b cycle, negative=0.
REQ-037 a=3, b=5, op=01 -> result=0xFE, negative=1, error=0.
REQ-038 a=15, b=15, op=10 -> busy for 5 cycles, result=0xE1 valid 6 cycles after the load_b cycle.
REQ-039 a=13, b=4, op=11 -> result=0x13 (remainder 1, quotient 3); a=13, b=0, op=11 -> result=0xFF, error=1 after 1 COMPUTE cycle.
REQ-040 Multiply 15*15, pulse enter during COMPUTE, then assert async reset at the 3rd COMPUTE cycle -> enter has no effect, state=GET_A immediately, all outputs 0, next enter pulses load_a.
REQ-041 In DONE, enter and clr in the same cycle -> load_a=0, state GET_A next cycle, result=0.
